// File: rtl/dataframe_pkg.sv
// rtl/dataframe_pkg.sv - shared types and constants for the downlink frame playback buffer
// Contents: FRAME_W (frame word width), IDLE_WORD_DEFAULT (word driven while not playing),
//           state_t (playback controller states).
package dataframe_pkg;

    localparam int FRAME_W = 32;

    localparam logic [FRAME_W-1:0] IDLE_WORD_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/dataframe_ram.sv
// rtl/dataframe_ram.sv - 1W/1R synchronous-read frame buffer, 2**DEPTH_LOG2 x FRAME_W
// Ports:
//   clk      frame clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address, sampled every cycle
//   rd_data  registered read data, one cycle after rd_addr
module dataframe_ram
    import dataframe_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [FRAME_W-1:0]    wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [FRAME_W-1:0]    rd_data
);

    logic [FRAME_W-1:0] mem [2**DEPTH_LOG2];

    // No reset on the array or read register so this maps onto block RAM.
    // A read and write to the same address on one edge returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dataframe_send.sv
// rtl/dataframe_send.sv - downlink playback buffer streaming one 32-bit word per 40 MHz frame
// Ports:
//   clk40_i, rst_i          frame clock, synchronous active-high reset
//   wr_en_i/addr/data       host write port into the playback buffer
//   nframes_i, nloops_i     words per pass and pass count (0 = until stopped), sampled at start
//   start_i, stop_i         single-cycle control pulses
//   downlinkrdy_i           lpGBT downlink ready; dropping it aborts playback
//   downlinkUserData_o      frame word to lpGBT, IDLE_WORD when not playing
//   busy_o, done_o, rdy_lost_o, loop_cnt_o   status
module dataframe_send
    import dataframe_pkg::*;
#(
    parameter int                 DEPTH_LOG2 = 8,
    parameter logic [FRAME_W-1:0] IDLE_WORD  = IDLE_WORD_DEFAULT
) (
    input  logic                  clk40_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [FRAME_W-1:0]    wr_data_i,
    input  logic [DEPTH_LOG2:0]   nframes_i,
    input  logic [15:0]           nloops_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  downlinkrdy_i,
    output logic [FRAME_W-1:0]    downlinkUserData_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rdy_lost_o,
    output logic [15:0]           loop_cnt_o
);

    state_t                state;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DEPTH_LOG2:0]   nframes_m1;
    logic [15:0]           nloops_q;
    logic                  issuing;   // a RAM read is launched at the coming edge
    logic                  rd_valid;  // RAM read register holds a word to be played
    logic                  abort_q;   // run is being torn down by stop or ready loss
    logic                  lost_q;    // the teardown was caused by ready loss
    logic [FRAME_W-1:0]    ram_rd_data;

    logic start_ok;
    logic abort_req;
    logic last_of_pass;
    logic last_pass;
    logic drained;

    assign start_ok     = start_i && downlinkrdy_i && (nframes_i != '0) && !stop_i;
    assign abort_req    = stop_i || !downlinkrdy_i;
    assign last_of_pass = ({1'b0, rd_addr} == nframes_m1);
    assign last_pass    = (nloops_q != 16'd0) && (loop_cnt_o == nloops_q - 16'd1);
    // Nothing left in the read pipeline: the output register is taking IDLE_WORD now.
    assign drained      = (state == PLAY) && !issuing && !rd_valid;

    dataframe_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk     (clk40_i),
        .wr_en   (wr_en_i),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk40_i) begin
        if (rst_i) begin
            state              <= IDLE;
            rd_addr            <= '0;
            nframes_m1         <= '0;
            nloops_q           <= 16'd0;
            issuing            <= 1'b0;
            rd_valid           <= 1'b0;
            abort_q            <= 1'b0;
            lost_q             <= 1'b0;
            downlinkUserData_o <= IDLE_WORD;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
            rdy_lost_o         <= 1'b0;
            loop_cnt_o         <= 16'd0;
        end else begin
            downlinkUserData_o <= rd_valid ? ram_rd_data : IDLE_WORD;

            case (state)
                IDLE: begin
                    issuing  <= 1'b0;
                    rd_valid <= 1'b0;
                end
                PLAY: begin
                    if (drained) begin
                        state      <= IDLE;
                        busy_o     <= 1'b0;
                        done_o     <= !abort_q;
                        rdy_lost_o <= lost_q;
                    end else if (!abort_q && abort_req) begin
                        // Flush: the word already in the output path still plays this
                        // edge, everything behind it is discarded and no read is issued.
                        issuing  <= 1'b0;
                        rd_valid <= 1'b0;
                        abort_q  <= 1'b1;
                        lost_q   <= !stop_i;
                    end else if (issuing) begin
                        rd_valid <= 1'b1;
                        if (last_of_pass) begin
                            rd_addr <= '0;
                            if (loop_cnt_o != 16'hFFFF) begin
                                loop_cnt_o <= loop_cnt_o + 16'd1;
                            end
                            if (last_pass) begin
                                issuing <= 1'b0;
                            end
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end else begin
                        rd_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new run may begin on the same edge the previous one retires.
            if (start_ok && (state == IDLE || drained)) begin
                state      <= PLAY;
                nframes_m1 <= nframes_i - 1'b1;
                nloops_q   <= nloops_i;
                rd_addr    <= '0;
                loop_cnt_o <= 16'd0;
                done_o     <= 1'b0;
                rdy_lost_o <= 1'b0;
                busy_o     <= 1'b1;
                issuing    <= 1'b1;
                rd_valid   <= 1'b0;
                abort_q    <= 1'b0;
                lost_q     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dataframe_send.sv
// tb/tb_dataframe_send.sv - self-checking bench for dataframe_send
module tb_dataframe_send;

    localparam int          DL     = 8;
    localparam logic [31:0] IDLE_W = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          wr_en_i;
    logic [DL-1:0] wr_addr_i;
    logic [31:0]   wr_data_i;
    logic [DL:0]   nframes_i;
    logic [15:0]   nloops_i;
    logic          start_i;
    logic          stop_i;
    logic          downlinkrdy_i;
    logic [31:0]   downlinkUserData_o;
    logic          busy_o;
    logic          done_o;
    logic          rdy_lost_o;
    logic [15:0]   loop_cnt_o;

    always #5 clk = ~clk;

    dataframe_send #(
        .DEPTH_LOG2(DL),
        .IDLE_WORD (IDLE_W)
    ) dut (
        .clk40_i            (clk),
        .rst_i              (rst_i),
        .wr_en_i            (wr_en_i),
        .wr_addr_i          (wr_addr_i),
        .wr_data_i          (wr_data_i),
        .nframes_i          (nframes_i),
        .nloops_i           (nloops_i),
        .start_i            (start_i),
        .stop_i             (stop_i),
        .downlinkrdy_i      (downlinkrdy_i),
        .downlinkUserData_o (downlinkUserData_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .rdy_lost_o         (rdy_lost_o),
        .loop_cnt_o         (loop_cnt_o)
    );

    // abort_kind: 0 none, 1 stop_i, 2 downlinkrdy_i drop; offsets are edges after the start edge
    typedef struct {
        int nframes;
        int nloops;
        int abort_off;
        int abort_kind;
        int bstart_off;
        int exp_cnt;
        int exp_done;
        int exp_lost;
    } run_t;

    typedef struct {
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic        lost;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [256];
    run_t        rows [8];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int cnt_at(input int e, input int f, input int l);
        int c;
        int lim;
        c   = e / f;
        lim = (l == 0) ? 65535 : l;
        return (c > lim) ? lim : c;
    endfunction

    // Expected output per edge after the start edge, derived from the buffer model.
    task automatic push_expected(input run_t v);
        exp_t r;
        for (int e = 1; e < 100000; e++) begin
            if (v.abort_off != 0 && e == v.abort_off + 1) begin
                r = '{IDLE_W, 1'b0, 1'b0, (v.abort_kind == 2), 16'(cnt_at(v.abort_off - 1, v.nframes, v.nloops))};
                sb.push_back(r);
                break;
            end
            if (v.nloops != 0 && e == v.nframes * v.nloops + 2) begin
                r = '{IDLE_W, 1'b0, 1'b1, 1'b0, 16'(v.nloops)};
                sb.push_back(r);
                break;
            end
            r.data = (e >= 2) ? model_mem[(e - 2) % v.nframes] : IDLE_W;
            r.busy = 1'b1;
            r.done = 1'b0;
            r.lost = 1'b0;
            r.cnt  = (e == v.abort_off) ? 16'(cnt_at(e - 1, v.nframes, v.nloops))
                                        : 16'(cnt_at(e, v.nframes, v.nloops));
            sb.push_back(r);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t r);
        chk({tag, " data"}, downlinkUserData_o, r.data);
        chk({tag, " busy"}, 32'(busy_o), 32'(r.busy));
        chk({tag, " done"}, 32'(done_o), 32'(r.done));
        chk({tag, " lost"}, 32'(rdy_lost_o), 32'(r.lost));
        chk({tag, " cnt"},  32'(loop_cnt_o), 32'(r.cnt));
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = DL'(a);
        wr_data_i = d;
        @(posedge clk);
        #1;
        wr_en_i      = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic run_vec(input int idx, input run_t v);
        exp_t r;
        int   e;
        nframes_i = (DL+1)'(v.nframes);
        nloops_i  = 16'(v.nloops);
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        push_expected(v);
        e = 1;
        while (sb.size() > 0) begin
            if (e == v.abort_off && v.abort_kind == 1) stop_i = 1'b1;
            if (e == v.abort_off && v.abort_kind == 2) downlinkrdy_i = 1'b0;
            if (e == v.bstart_off) begin
                start_i   = 1'b1;
                nframes_i = (DL+1)'(1);
                nloops_i  = 16'd7;
            end
            @(posedge clk);
            #1;
            start_i       = 1'b0;
            stop_i        = 1'b0;
            downlinkrdy_i = 1'b1;
            nframes_i     = (DL+1)'(v.nframes);
            nloops_i      = 16'(v.nloops);
            r = sb.pop_front();
            check_outputs($sformatf("row%0d e%0d", idx, e), r);
            e++;
        end
        chk($sformatf("row%0d final cnt", idx), 32'(loop_cnt_o), 32'(v.exp_cnt));
        chk($sformatf("row%0d final done", idx), 32'(done_o), 32'(v.exp_done));
        chk($sformatf("row%0d final lost", idx), 32'(rdy_lost_o), 32'(v.exp_lost));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("row%0d idle data", idx), downlinkUserData_o, IDLE_W);
            chk($sformatf("row%0d idle busy", idx), 32'(busy_o), 32'd0);
        end
    endtask

    // Starts that must be ignored: ready low, then nframes of zero; flags stay as left.
    task automatic ignored_starts(input logic exp_done, input logic exp_lost, input logic [15:0] exp_cnt);
        exp_t r;
        r = '{IDLE_W, 1'b0, exp_done, exp_lost, exp_cnt};
        for (int m = 0; m < 2; m++) begin
            nframes_i     = (m == 0) ? (DL+1)'(4) : (DL+1)'(0);
            nloops_i      = 16'd1;
            downlinkrdy_i = (m != 0);
            start_i       = 1'b1;
            @(posedge clk);
            #1;
            start_i       = 1'b0;
            downlinkrdy_i = 1'b1;
            for (int k = 0; k < 3; k++) begin
                check_outputs($sformatf("ignored_start%0d k%0d", m, k), r);
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rows[0] = '{4,   1, 0,  0, 0, 1,  1, 0};
        rows[1] = '{3,   2, 0,  0, 0, 2,  1, 0};
        rows[2] = '{1,   3, 0,  0, 0, 3,  1, 0};
        rows[3] = '{3,   0, 11, 1, 0, 3,  0, 0};
        rows[4] = '{4,   3, 6,  2, 0, 1,  0, 1};
        rows[5] = '{5,   2, 0,  0, 4, 2,  1, 0};
        rows[6] = '{256, 1, 0,  0, 0, 1,  1, 0};
        rows[7] = '{2,   0, 40, 1, 0, 19, 0, 0};

        rst_i         = 1'b1;
        wr_en_i       = 1'b0;
        wr_addr_i     = '0;
        wr_data_i     = '0;
        nframes_i     = '0;
        nloops_i      = '0;
        start_i       = 1'b0;
        stop_i        = 1'b0;
        downlinkrdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", '{IDLE_W, 1'b0, 1'b0, 1'b0, 16'd0});
        rst_i = 1'b0;

        for (int a = 0; a < 256; a++) begin
            write_word(a, 32'h0000_00A0 + 32'(a));
        end

        for (int i = 0; i < 8; i++) begin
            run_vec(i, rows[i]);
            if (i == 4) ignored_starts(1'b0, 1'b1, 16'd1);
        end

        // Reset in the middle of a looping run.
        nframes_i = (DL+1)'(4);
        nloops_i  = 16'd0;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre-reset busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_outputs("mid reset", '{IDLE_W, 1'b0, 1'b0, 1'b0, 16'd0});
        @(posedge clk);
        #1;
        check_outputs("post reset", '{IDLE_W, 1'b0, 1'b0, 1'b0, 16'd0});

        run_vec(8, rows[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
